// File: rtl/frame_pkg.sv
// frame_pkg: constants and types shared across the frame write-back slice.
//   LINE_W/ROWS/ADDR_W/MISS_ROW : default display geometry
//   line_t      : one display row, bit 0 = leftmost pixel
//   row_entry_t : {addr, line} as buffered by the write-back FIFO
//   fwb_state_t : write-back FSM states
package frame_pkg;

    localparam int LINE_W   = 480;
    localparam int ROWS     = 640;
    localparam int ADDR_W   = 10;
    localparam int MISS_ROW = 577;

    typedef logic [0:LINE_W-1] line_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        line_t             line;
    } row_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } fwb_state_t;

endpackage

// File: rtl/row_fifo.sv
// row_fifo: synchronous FIFO with extra-MSB pointers; head is always visible.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : store i_data at the tail (caller guarantees space)
//   i_pop     : advance the head (caller guarantees non-empty)
//   i_data    : entry to store
//   o_head    : current head entry
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
module row_fifo
    import frame_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(row_entry_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    // Same slot index but different lap bit means the writer is one lap ahead.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/frame_writeback.sv
// frame_writeback: buffers updated display rows and commits them to the shared
// single-port frame RAM whenever the VGA scanner is not using the port.
// Optional miss detection is built when FWB_MISS_DETECT_EN is defined.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   wr_valid/addr/line   : one-cycle row update from upstream
//   vga_active, vga_addr : scanner owns the RAM port / scanner row address
//   ram_addr/we/wdata    : RAM port
//   full                 : FIFO holds DEPTH entries
//   overflow             : sticky, a row update was dropped
//   miss_pulse           : one cycle per popped non-empty MISS_ROW row
//   miss_count           : saturating miss counter
module frame_writeback
    import frame_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LINE_W   = frame_pkg::LINE_W,
    parameter int ADDR_W   = frame_pkg::ADDR_W,
    parameter int ROWS     = frame_pkg::ROWS,
    parameter int MISS_ROW = frame_pkg::MISS_ROW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [0:LINE_W-1] wr_line,
    input  logic              vga_active,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [0:LINE_W-1] ram_wdata,
    output logic              full,
    output logic              overflow,
    output logic              miss_pulse,
    output logic [7:0]        miss_count
);

    localparam int ENTRY_W = ADDR_W + LINE_W;
    localparam logic [ADDR_W:0] ROWS_LIM = (ADDR_W+1)'(ROWS);

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [0:LINE_W-1]  w_head_line;
    fwb_state_t         w_state_nxt;

    fwb_state_t         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [0:LINE_W-1]  r_data;
    logic               r_wr_ok;
    logic               r_overflow;

    row_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({wr_addr, wr_line}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_addr, w_head_line} = w_head;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !vga_active) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = wr_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr_ok    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (wr_valid && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_pop) begin
                r_addr  <= w_head_addr;
                r_data  <= w_head_line;
                // Out-of-range rows still take the WRITE slot but never strobe.
                r_wr_ok <= ({1'b0, w_head_addr} < ROWS_LIM);
            end
        end
    end

    assign ram_we    = (r_state == WRITE) && r_wr_ok;
    assign ram_wdata = r_data;
    assign ram_addr  = (vga_active && (r_state != WRITE)) ? vga_addr : r_addr;
    assign full      = w_full;
    assign overflow  = r_overflow;

`ifdef FWB_MISS_DETECT_EN
    logic       w_miss_hit;
    logic       r_miss_pulse;
    logic [7:0] r_miss_count;

    assign w_miss_hit = w_pop && (w_head_addr == ADDR_W'(MISS_ROW)) && (|w_head_line);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss_pulse <= 1'b0;
            r_miss_count <= '0;
        end else begin
            r_miss_pulse <= w_miss_hit;
            if (w_miss_hit && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 8'd1;
        end
    end

    assign miss_pulse = r_miss_pulse;
    assign miss_count = r_miss_count;
`else
    assign miss_pulse = 1'b0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_frame_writeback.sv
// tb_frame_writeback: directed self-checking bench for frame_writeback.
module tb_frame_writeback;

    localparam int LW = 480;
    localparam int AW = 10;

`ifdef FWB_MISS_DETECT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [0:LW-1] wr_line = '0;
    logic          vga_active = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [0:LW-1] ram_wdata;
    logic          full;
    logic          overflow;
    logic          miss_pulse;
    logic [7:0]    miss_count;

    int n_vec  = 0;
    int n_fail = 0;

    frame_writeback #(
        .DEPTH    (4),
        .LINE_W   (LW),
        .ADDR_W   (AW),
        .ROWS     (640),
        .MISS_ROW (577)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_line    (wr_line),
        .vga_active (vga_active),
        .vga_addr   (vga_addr),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .full       (full),
        .overflow   (overflow),
        .miss_pulse (miss_pulse),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:LW-1] onehot(input int b);
        logic [0:LW-1] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic drive(input int addr, input logic [0:LW-1] line);
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_line  = line;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_we",     LW'(ram_we),     LW'(0));
        chk("rst_wdata",  ram_wdata,       LW'(0));
        chk("rst_full",   LW'(full),       LW'(0));
        chk("rst_ovf",    LW'(overflow),   LW'(0));
        chk("rst_mpulse", LW'(miss_pulse), LW'(0));
        chk("rst_mcount", LW'(miss_count), LW'(0));
        chk("rst_addr",   LW'(ram_addr),   LW'(0));
        rst = 1'b0;

        // Single push, minimum latency
        drive(100, '1);
        step();
        wr_valid = 1'b0;
        chk("t1_we_pre", LW'(ram_we), LW'(0));
        step();
        chk("t1_we",   LW'(ram_we),   LW'(1));
        chk("t1_addr", LW'(ram_addr), LW'(100));
        chk("t1_data", ram_wdata,     {LW{1'b1}});
        step();
        chk("t1_we_off", LW'(ram_we), LW'(0));

        // Scanner busy: no writes, address follows scanner
        vga_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 3) drive(10 + i, onehot(10 + i));
            else       wr_valid = 1'b0;
            vga_addr = AW'(300 + i);
            step();
            chk("t2_we_blk",   LW'(ram_we),   LW'(0));
            chk("t2_addr_vga", LW'(ram_addr), LW'(300 + i));
        end
        vga_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_we",   LW'(ram_we),   LW'(1));
            chk("t2_addr", LW'(ram_addr), LW'(10 + k));
            chk("t2_data", ram_wdata,     onehot(10 + k));
            step();
            chk("t2_gap",  LW'(ram_we),   LW'(0));
        end

        // Fill, overflow, drain; fifth row dropped
        vga_active = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(i, onehot(i));
            step();
            chk("t3_full", LW'(full),     LW'(i >= 4));
            chk("t3_ovf",  LW'(overflow), LW'(i == 5));
        end
        wr_valid   = 1'b0;
        vga_active = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_we",       LW'(ram_we),   LW'(1));
            chk("t3_addr",     LW'(ram_addr), LW'(k));
            chk("t3_full_off", LW'(full),     LW'(0));
            step();
            chk("t3_gap",      LW'(ram_we),   LW'(0));
        end
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_no_row5", LW'(ram_we), LW'(0));
        end
        chk("t3_ovf_sticky", LW'(overflow), LW'(1));

        // Out-of-range row discarded, next row still written
        drive(700, '1);
        step();
        drive(5, onehot(5));
        step();
        wr_valid = 1'b0;
        chk("t4_we_700", LW'(ram_we), LW'(0));
        step();
        chk("t4_we_idle", LW'(ram_we), LW'(0));
        step();
        chk("t4_we",   LW'(ram_we),   LW'(1));
        chk("t4_addr", LW'(ram_addr), LW'(5));
        step();
        chk("t4_gap",  LW'(ram_we),   LW'(0));

        // Miss detection
        for (int n = 0; n < 3; n++) begin
            drive(577, onehot(33));
            step();
            wr_valid = 1'b0;
            step();
            chk("t5_pulse",    LW'(miss_pulse), LW'(MISS_EN));
            chk("t5_we",       LW'(ram_we),     LW'(1));
            step();
            chk("t5_pulse_lo", LW'(miss_pulse), LW'(0));
        end
        chk("t5_count3", LW'(miss_count), LW'(MISS_EN ? 3 : 0));
        drive(577, '0);
        step();
        wr_valid = 1'b0;
        step();
        chk("t5_zero_row", LW'(miss_pulse), LW'(0));
        step();
        drive(576, onehot(33));
        step();
        wr_valid = 1'b0;
        step();
        chk("t5_other_row", LW'(miss_pulse), LW'(0));
        step();
        chk("t5_count_hold", LW'(miss_count), LW'(MISS_EN ? 3 : 0));
        for (int n = 0; n < 297; n++) begin
            drive(577, onehot(33));
            step();
            wr_valid = 1'b0;
            step();
            step();
        end
        chk("t5_count_sat", LW'(miss_count), LW'(MISS_EN ? 255 : 0));

        // Reset during WRITE drops the buffered row
        drive(20, onehot(20));
        step();
        drive(21, onehot(21));
        step();
        wr_valid = 1'b0;
        chk("t6_we",   LW'(ram_we),   LW'(1));
        chk("t6_addr", LW'(ram_addr), LW'(20));
        rst = 1'b1;
        step();
        chk("t6_we_rst",   LW'(ram_we),     LW'(0));
        chk("t6_full_rst", LW'(full),       LW'(0));
        chk("t6_ovf_rst",  LW'(overflow),   LW'(0));
        chk("t6_cnt_rst",  LW'(miss_count), LW'(0));
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_empty", LW'(ram_we), LW'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_writeback.md
# frame_writeback

Write-back stage directly downstream of the falling-line update stage. It takes each updated 480-bit display row (row address + data + one-cycle valid strobe) and buffers it in a small FIFO. It commits the row to the shared single-port frame RAM only while the VGA scanner is not reading, and flags rows that reach the miss row with glyph pixels still set.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- LINE_W, 480: bits per display row.
- ADDR_W, 10: row address width.
- ROWS, 640: valid row addresses are 0..ROWS-1.
- MISS_ROW, 577: row whose non-zero content counts as a miss.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  one-cycle strobe from the upstream stage's ready.
- wr_addr  in  ADDR_W  row address (upstream w_addr).
- wr_line  in  [0:LINE_W-1]  row data (upstream FallLine); bit 0 is the leftmost pixel.
- vga_active  in  1  high while the scanner owns the RAM port.
- vga_addr  in  ADDR_W  scanner row address.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  [0:LINE_W-1]  RAM write data.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a strobe was dropped.
- miss_pulse  out  1  one-cycle pulse per miss.
- miss_count  out  8  saturating miss counter.

## Operation
- Reset: FIFO empty, FSM in IDLE. All outputs are 0: ram_we, ram_wdata, full, overflow, miss_pulse, miss_count. ram_addr follows its mux rule.
- Push: when wr_valid=1 and (not full, or a pop occurs in the same cycle), the entry {wr_addr, wr_line} is stored at the tail.
- Dropped push: when wr_valid=1, full=1 and no pop occurs, the entry is dropped and overflow is set to 1. overflow clears only on rst.
- FSM states:
  - IDLE: if the FIFO is non-empty and vga_active=0, pop the head and go to WRITE.
  - WRITE: ram_we=1 for exactly one cycle with the popped addr/data. Then go to IDLE.
  - If vga_active rises while in WRITE, the write still completes. The scanner tolerates one stolen cycle.
- Out-of-range entries: a popped entry with addr >= ROWS is discarded. ram_we stays 0 and the FSM returns to IDLE. That pop still counts as a pop for the push rule.
- ram_addr mux: when vga_active=1 and the FSM is not in WRITE, ram_addr = vga_addr (combinational). Otherwise ram_addr is the registered write address.
- Pointer arithmetic: read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full and empty are derived from pointer MSB and LSB comparison.
- Miss detect (macro enabled): on a pop with addr == MISS_ROW and any data bit = 1, miss_pulse=1 in the WRITE cycle. miss_count increments and saturates at 255.

## Timing
- Push strobe at edge N: the entry is at the head by edge N+1.
- If vga_active=0 at edge N+1, the pop happens there and ram_we=1 in the cycle following edge N+1 (first write visible cycle N+1→N+2).
- Minimum push-to-write latency is 1 cycle. Maximum sustained write rate is one row per 2 cycles.
- full updates at the same edge as the push/pop that changes occupancy.
- Simultaneous push and pop when empty: the push lands and the pop is not possible that cycle; the FIFO was empty at the decision edge.
- Reset asserted mid-WRITE: ram_we is 0 from the next cycle and the buffered entry is lost.

## Configuration
- FWB_MISS_DETECT_EN defined: the miss-detect comparator, miss_pulse and miss_count are built as described above.
- FWB_MISS_DETECT_EN undefined: the miss logic is not built. miss_pulse and miss_count are tied to 0. Write-back behaviour is unchanged.

## Structure
- Shared package frame_pkg holds:
  - constants LINE_W=480, ROWS=640, ADDR_W=10, MISS_ROW=577;
  - typedef line_t [0:479];
  - typedef row_entry_t {addr, line};
  - FSM enum fwb_state_t {IDLE, WRITE}.
- One sub-module, row_fifo: a parameterised synchronous FIFO with push, pop, full, empty and head outputs. frame_writeback contains the FSM, RAM mux and miss logic.

## Test plan
- Reset, then a single push of addr=100, line=all-ones with vga_active=0 → ram_we=1 exactly one cycle later, with ram_addr=100 and ram_wdata all ones.
- vga_active=1 held for 20 cycles while pushing rows 10, 11, 12 → no ram_we, ram_addr tracks vga_addr. After vga_active falls, three writes occur in order 10, 11, 12, two cycles apart.
- vga_active=1 with 5 consecutive pushes at DEPTH=4 → full=1 after the 4th push, overflow=1 after the 5th. Rows 1–4 are written once vga_active=0, and row 5 is never written.
- Push addr=700 then addr=5 → no write for 700, and the write for 5 follows.
- With FWB_MISS_DETECT_EN, push addr=577 with bit 33 set three times → three miss_pulse cycles, miss_count=3. 300 such pushes → miss_count=255.
- rst asserted during the WRITE cycle → ram_we=0 next cycle, full=0, overflow=0, FIFO empty.
